// File: rtl/result_seg7_scanner.sv
// Multiplexed 4-digit hex display for a divider result: latches quotient and
// remainder on done, then scans digits and alternates between the two pages.
module result_seg7_scanner #(
  parameter int SCAN_DIV   = 50000,
  parameter int PAGE_SCANS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        done,
  input  logic [15:0] quotient,
  input  logic [15:0] remainder,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        page,
  output logic        valid
);

  localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FRAME_W = (PAGE_SCANS > 1) ? $clog2(PAGE_SCANS) : 1;
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(PAGE_SCANS - 1);

  logic [15:0]        r_quot;
  logic [15:0]        r_rem;
  logic [SCAN_W-1:0]  r_scan;
  logic [FRAME_W-1:0] r_frame;
  logic [1:0]         r_digit;
  logic               r_page;
  logic               r_valid;

  logic [15:0] w_word;
  logic [3:0]  w_nib;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_quot  <= '0;
      r_rem   <= '0;
      r_scan  <= '0;
      r_frame <= '0;
      r_digit <= '0;
      r_page  <= 1'b0;
      r_valid <= 1'b0;
    end else if (done) begin
      // A new result always restarts the display from digit 0 of the quotient.
      r_quot  <= quotient;
      r_rem   <= remainder;
      r_scan  <= '0;
      r_frame <= '0;
      r_digit <= '0;
      r_page  <= 1'b0;
      r_valid <= 1'b1;
    end else if (r_valid) begin
      if (r_scan == SCAN_LAST) begin
        r_scan  <= '0;
        r_digit <= r_digit + 2'd1;
        if (r_digit == 2'd3) begin
          if (r_frame == FRAME_LAST) begin
            r_frame <= '0;
            r_page  <= ~r_page;
          end else begin
            r_frame <= r_frame + FRAME_W'(1);
          end
        end
      end else begin
        r_scan <= r_scan + SCAN_W'(1);
      end
    end
  end

  always_comb begin
    w_word = r_page ? r_rem : r_quot;
    case (r_digit)
      2'd0:    w_nib = w_word[3:0];
      2'd1:    w_nib = w_word[7:4];
      2'd2:    w_nib = w_word[11:8];
      default: w_nib = w_word[15:12];
    endcase
  end

  always_comb begin
    seg = 7'h00;
    an  = 4'b1111;
    if (r_valid) begin
      an = ~(4'b0001 << r_digit);
      case (w_nib)
        4'h0: seg = 7'h3F;
        4'h1: seg = 7'h06;
        4'h2: seg = 7'h5B;
        4'h3: seg = 7'h4F;
        4'h4: seg = 7'h66;
        4'h5: seg = 7'h6D;
        4'h6: seg = 7'h7D;
        4'h7: seg = 7'h07;
        4'h8: seg = 7'h7F;
        4'h9: seg = 7'h6F;
        4'hA: seg = 7'h77;
        4'hB: seg = 7'h7C;
        4'hC: seg = 7'h39;
        4'hD: seg = 7'h5E;
        4'hE: seg = 7'h79;
        default: seg = 7'h71;
      endcase
    end
  end

  assign page  = r_page;
  assign valid = r_valid;

endmodule

// File: tb/tb_result_seg7_scanner.sv
// Bench for result_seg7_scanner: a time-since-latch model predicts each cycle's
// {valid,page,an,seg}, plus directed checks of the documented display sequence.
module tb_result_seg7_scanner;

  localparam int SD = 2;
  localparam int PS = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        done = 1'b0;
  logic [15:0] quotient = '0;
  logic [15:0] remainder = '0;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        page;
  logic        valid;

  int n_checks = 0;
  int n_errors = 0;

  logic [12:0] exp_q[$];

  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model: only the latched values and elapsed cycles since the latch.
  logic        m_valid;
  logic [15:0] m_q;
  logic [15:0] m_r;
  int          m_t;

  result_seg7_scanner #(.SCAN_DIV(SD), .PAGE_SCANS(PS)) dut (
    .clk(clk), .rst(rst), .done(done), .quotient(quotient), .remainder(remainder),
    .seg(seg), .an(an), .page(page), .valid(valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [12:0] model_out();
    int d;
    int p;
    logic [15:0] w;
    if (!m_valid) return {1'b0, 1'b0, 4'b1111, 7'h00};
    d = (m_t / SD) % 4;
    p = (m_t / (4 * SD * PS)) % 2;
    w = (p == 1) ? m_r : m_q;
    return {1'b1, p[0], ~(4'b0001 << d), glyph[(w >> (4 * d)) & 16'hF]};
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_q = '0;
    m_r = '0;
    m_t = 0;
  endtask

  // Called at a falling edge: drive one cycle, predict, then compare after the rising edge.
  task automatic drive_cycle(input logic d, input logic [15:0] q, input logic [15:0] r);
    logic [12:0] e;
    done = d;
    quotient = q;
    remainder = r;
    if (d) begin
      m_valid = 1'b1;
      m_q = q;
      m_r = r;
      m_t = 0;
    end else if (m_valid) begin
      m_t++;
    end
    exp_q.push_back(model_out());
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("scoreboard", {19'd0, valid, page, an, seg}, {19'd0, e});
    end
    @(negedge clk);
    done = 1'b0;
  endtask

  initial begin
    model_reset();
    #3;
    check("reset_an", {28'd0, an}, 32'hF);
    check("reset_seg", {25'd0, seg}, 32'h00);
    check("reset_page_valid", {30'd0, page, valid}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 16'h0, 16'h0);

    // Latch then walk the display sequence
    drive_cycle(1'b1, 16'h1234, 16'h00AF);
    check("latch", {19'd0, valid, page, an, seg}, {19'd0, 1'b1, 1'b0, 4'b1110, 7'h66});
    for (int i = 1; i <= 20; i++) begin
      drive_cycle(1'b0, 16'hDEAD, 16'hBEEF);
      case (i)
        2:  check("scan_d1", {21'd0, page, an, seg}, {21'd0, 1'b0, 4'b1101, 7'h4F});
        4:  check("scan_d2", {21'd0, page, an, seg}, {21'd0, 1'b0, 4'b1011, 7'h5B});
        6:  check("scan_d3", {21'd0, page, an, seg}, {21'd0, 1'b0, 4'b0111, 7'h06});
        16: check("page_d0", {21'd0, page, an, seg}, {21'd0, 1'b1, 4'b1110, 7'h71});
        18: check("page_d1", {21'd0, page, an, seg}, {21'd0, 1'b1, 4'b1101, 7'h77});
        20: check("page_d2", {21'd0, page, an, seg}, {21'd0, 1'b1, 4'b1011, 7'h3F});
        default: ;
      endcase
    end

    drive_cycle(1'b1, 16'hFFFF, 16'h1234);
    check("relatch", {21'd0, page, an, seg}, {21'd0, 1'b0, 4'b1110, 7'h71});
    drive_cycle(1'b0, 16'h0, 16'h0);
    drive_cycle(1'b0, 16'h0, 16'h0);
    check("relatch_d1", {28'd0, an}, 32'b1101);

    // Hold done high with changing quotients
    for (int i = 0; i < 5; i++) begin
      logic [15:0] q;
      q = 16'($urandom_range(0, 65535));
      drive_cycle(1'b1, q, 16'h5A5A);
      check("hold", {21'd0, page, an, seg}, {21'd0, 1'b0, 4'b1110, glyph[q[3:0]]});
    end

    // Random traffic with sparse done pulses
    for (int i = 0; i < 300; i++) begin
      drive_cycle(($urandom_range(0, 40) == 0), 16'($urandom_range(0, 65535)),
                  16'($urandom_range(0, 65535)));
    end

    // Asynchronous reset between edges, done ignored while held
    #2;
    rst = 1'b0;
    #1;
    check("async_reset", {19'd0, valid, page, an, seg}, {19'd0, 1'b0, 1'b0, 4'b1111, 7'h00});
    model_reset();
    @(negedge clk);
    done = 1'b1;
    quotient = 16'h1111;
    @(posedge clk);
    #1;
    check("reset_ignores_done", {19'd0, valid, page, an, seg}, {19'd0, 13'b0_0_1111_0000000});
    @(negedge clk);
    done = 1'b0;
    rst = 1'b1;
    drive_cycle(1'b0, 16'h0, 16'h0);
    check("post_reset_invalid", {31'd0, valid}, 32'd0);
    drive_cycle(1'b1, 16'h000C, 16'h0);
    drive_cycle(1'b0, 16'h0, 16'h0);
    check("post_reset_latch", {25'd0, seg}, 32'h39);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
